// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encoding, datapath select codes and the Moore control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    R_EXEC,
    R_WB,
    I_EXEC,
    I_WB,
    BRANCH,
    JUMP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_e;

  typedef struct packed {
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src_a;
    srcb_e  alu_src_b;
    aluop_e alu_op;
    pcsrc_e pc_source;
    logic   done;
  } moore_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure state-to-Moore-output decoder; handshake-gated strobes are added
// by the owning FSM.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output moore_t ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.done       = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.done      = 1'b1;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.done      = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.done      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath, with a ready
// handshake on memory accesses and a bounded wait timeout.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout
);

  // Abort fires on the cycle that would be the MEM_TIMEOUT-th consecutive stall.
  localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);

  state_e     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  moore_t     m;
  logic       pc_en_c, ir_write_c, done_c, illegal_c, timeout_c, waiting;

  ctrl_output_decode u_decode (
    .state (state),
    .ctrl  (m)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign waiting = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);

  always_comb begin
    state_nxt  = state;
    wait_nxt   = '0;
    pc_en_c    = 1'b0;
    ir_write_c = 1'b0;
    done_c     = m.done;
    illegal_c  = 1'b0;
    timeout_c  = 1'b0;

    unique case (state)
      FETCH: begin
        pc_en_c    = mem_ready;
        ir_write_c = mem_ready;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        case (opcode)
          OPC_W'(OP_RTYPE):      state_nxt = R_EXEC;
          OPC_W'(OP_LW),
          OPC_W'(OP_SW):         state_nxt = MEM_ADDR;
          OPC_W'(OP_ADDI):       state_nxt = I_EXEC;
          OPC_W'(OP_BEQ):        state_nxt = BRANCH;
          OPC_W'(OP_J):          state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            illegal_c = 1'b1;
            done_c    = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_nxt = (opcode == OPC_W'(OP_LW)) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) state_nxt = MEM_WB;
      MEM_WB:    state_nxt = FETCH;
      MEM_WRITE: begin
        if (mem_ready) begin
          done_c    = 1'b1;
          state_nxt = FETCH;
        end
      end
      R_EXEC:    state_nxt = R_WB;
      R_WB:      state_nxt = FETCH;
      I_EXEC:    state_nxt = I_WB;
      I_WB:      state_nxt = FETCH;
      BRANCH: begin
        pc_en_c   = Zero;
        state_nxt = FETCH;
      end
      JUMP: begin
        pc_en_c   = 1'b1;
        state_nxt = FETCH;
      end
      default:   state_nxt = FETCH;
    endcase

    // Stalled wait states count up (saturating); any exit or abort clears.
    if (waiting && !mem_ready) begin
      if ((MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
        timeout_c = 1'b1;
        state_nxt = FETCH;
      end else begin
        wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    pc_en       = reset ? 1'b0 : pc_en_c;
    PCSource    = reset ? '0   : m.pc_source;
    IorD        = reset ? 1'b0 : m.iord;
    MemRead     = reset ? 1'b0 : m.mem_read;
    MemWrite    = reset ? 1'b0 : m.mem_write;
    IRWrite     = reset ? 1'b0 : ir_write_c;
    MemtoReg    = reset ? 1'b0 : m.mem_to_reg;
    RegDst      = reset ? 1'b0 : m.reg_dst;
    RegWrite    = reset ? 1'b0 : m.reg_write;
    ALUSrcA     = reset ? 1'b0 : m.alu_src_a;
    ALUSrcB     = reset ? '0   : m.alu_src_b;
    ALUOp       = reset ? '0   : m.alu_op;
    instr_done  = reset ? 1'b0 : done_c;
    illegal_op  = reset ? 1'b0 : illegal_c;
    mem_timeout = reset ? 1'b0 : timeout_c;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multi-cycle MIPS datapath.
- Sequences the program counter, instruction register, memory, register file and ALU through fetch, decode, execute, memory and writeback steps.
- Generates the PC write enable, combining Zero with branch intent, and the PC source select that the PC block consumes.
- Supports variable-latency memory via a ready handshake.

Parameters:
- OPC_W, 6, opcode field width
- MEM_TIMEOUT, 15, maximum cycles spent waiting on mem_ready before abort; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OPC_W  instr[31:26] from instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_en  out  1  PC register load enable
- PCSource  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register writeback source: 1=MDR
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_timeout  out  1  one-cycle pulse on memory wait abort

Behaviour:
- Reset:
  - reset=1 at a clk edge sets state to FETCH and clears the wait counter.
  - While reset is high, all outputs are forced to 0, overriding the state decode.
  - The first FETCH cycle begins on the first edge with reset low.
  - Reset mid-instruction abandons the instruction with no further PC or register write.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Outputs are Moore (state-decoded), except pc_en and the handshake-gated strobes.
- FETCH:
  - IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and pc_en equal mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE on mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target precompute).
  - Opcode dispatch:
    - 000000 -> R_EXEC
    - 100011 (lw) -> MEM_ADDR
    - 101011 (sw) -> MEM_ADDR
    - 001000 (addi) -> I_EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other -> FETCH, with illegal_op=1 and instr_done=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; goes to MEM_READ for lw, MEM_WRITE for sw. The opcode is held stable by the IR.
- MEM_READ:
  - IorD=1, MemRead=1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; goes to FETCH.
- MEM_WRITE:
  - IorD=1, MemWrite=1.
  - On mem_ready: instr_done=1, go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
- I_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=0.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1.
  - pc_en = Zero, sampled combinationally in this cycle.
  - instr_done=1; goes to FETCH.
- JUMP: PCSource=2, pc_en=1, instr_done=1; goes to FETCH.
- Latency with mem_ready held 1:
  - beq and j: 3 cycles
  - R-type, sw and addi: 4 cycles
  - lw: 5 cycles
  - Each mem_ready=0 cycle in a wait state adds one cycle.
- Wait counter (4 bits):
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_READ and MEM_WRITE; clears on state exit.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: pulse mem_timeout and go to FETCH.
  - On that abort there is no pc_en, IRWrite or RegWrite, and no instr_done.
  - The counter saturates and never wraps.
- MemRead and MemWrite are never both 1.
- RegWrite, pc_en and MemWrite never assert in the same cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J)
  - state encoding
  - ALUOp, ALUSrcB and PCSource codes
- Next-state logic and the wait counter stay in multicycle_control_fsm.
- Optional sub-module ctrl_output_decode: pure state-to-Moore-output decoder, reused by a later pipelined controller.

Test Plan:
- Reset: assert reset 3 cycles mid-MEM_READ -> all outputs 0 during reset; first cycle after release is FETCH with MemRead=1, no RegWrite seen.
- lw with mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; pc_en only in cycle 1; RegWrite+MemtoReg in cycle 5; instr_done in cycle 5.
- beq, once with Zero=1 and once with Zero=0 -> 3 cycles each; in BRANCH, pc_en=1/PCSource=1 when Zero=1, pc_en=0 when Zero=0.
- j then R-type back-to-back -> j: pc_en=1, PCSource=2 in cycle 3; R-type: RegDst=1, RegWrite in cycle 7; two instr_done pulses total.
- sw with mem_ready low 4 cycles in MEM_WRITE -> MemWrite held 1 for 5 cycles, instr_done on the ready cycle, total 8 cycles.
- Opcode 111111 -> illegal_op pulse in DECODE, back to FETCH; mem_ready held 0 in FETCH for 15 cycles -> mem_timeout pulse, no IRWrite.
